// File: rtl/syscall_queue_if.sv
// syscall_queue_if: processor-side request bus and console-side output handshake for syscall_queue
interface syscall_queue_if #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
);
  logic [31:0] instr_ID;
  logic [31:0] rs;
  logic [WIDTH-1:0] rt;
  logic stall;
  logic out_valid;
  logic [WIDTH-1:0] out_data;
  logic out_ready;
  logic halt;
  logic [$clog2(DEPTH):0] count;
  modport master (
    output instr_ID, rs, rt, out_ready,
    input stall, out_valid, out_data, halt, count
  );
  modport slave (
    input instr_ID, rs, rt, out_ready,
    output stall, out_valid, out_data, halt, count
  );
endinterface

// File: rtl/syscall_queue.sv
// syscall_queue: display FIFO with exit drain/halt sequencing and processor back-pressure
// Optional macro SYSCALL_FWD_EN: bypass rt straight to out_data when the queue is empty and the sink is ready.
module syscall_queue #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input logic clk,
  input logic reset,
  syscall_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_e;
  state_e state_q, state_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [AW:0] count_q, count_d;
  logic disp_req, exit_req, fwd, push, pop;
  always_comb begin
    disp_req = bus.instr_ID == 32'd26 && bus.rs == 32'd1;
    exit_req = bus.instr_ID == 32'd26 && bus.rs != 32'd1;
`ifdef SYSCALL_FWD_EN
    fwd = state_q == RUN && count_q == '0 && disp_req && bus.out_ready;
`else
    fwd = 1'b0;
`endif
    // fullness is judged on the registered count, so a same-cycle pop never frees the slot
    push = state_q == RUN && disp_req && count_q != FULL && !fwd;
    pop = count_q != '0 && bus.out_ready;
    head_d = pop ? head_q + AW'(1) : head_q;
    tail_d = push ? tail_q + AW'(1) : tail_q;
    count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
    state_d = (state_q == RUN && exit_req) ? DRAIN :
              (state_q == DRAIN && count_q == '0) ? HALTED : state_q;
    bus.stall = (disp_req && (state_q != RUN || count_q == FULL)) || (exit_req && state_q != RUN);
    bus.out_valid = count_q != '0 || fwd;
    bus.out_data = fwd ? bus.rt : (count_q != '0 ? mem_q[head_q] : '0);
    bus.halt = state_q == HALTED;
    bus.count = count_q;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= RUN;
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= bus.rt;
  end
endmodule

// File: tb/tb_syscall_queue.sv
// tb_syscall_queue: directed scenarios plus randomized traffic against a queue-based reference model
module tb_syscall_queue;
  localparam int DEPTH = 8;
  localparam int WIDTH = 32;
`ifdef SYSCALL_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  logic [31:0] mq[$];
  bit m_exit = 1'b0;
  bit m_halt = 1'b0;
  syscall_queue_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();
  syscall_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic drive(input logic [31:0] id, input logic [31:0] r, input logic [31:0] v, input logic rdy);
    bus.instr_ID = id;
    bus.rs = r;
    bus.rt = v;
    bus.out_ready = rdy;
    @(negedge clk);
  endtask

  // advance one edge and update the reference model from the inputs seen at that edge
  task automatic step();
    int n;
    bit disp, ex, run, fw;
    @(posedge clk);
    n = mq.size();
    disp = bus.instr_ID == 26 && bus.rs == 1;
    ex = bus.instr_ID == 26 && bus.rs != 1;
    run = !m_exit && !m_halt;
    fw = FWD && run && n == 0 && disp && bus.out_ready;
    if (!reset) begin
      mq.delete();
      m_exit = 1'b0;
      m_halt = 1'b0;
    end else begin
      if (n != 0 && bus.out_ready) void'(mq.pop_front());
      if (run && disp && n < DEPTH && !fw) mq.push_back(bus.rt);
      if (m_exit && n == 0) begin
        m_halt = 1'b1;
        m_exit = 1'b0;
      end
      if (run && ex) m_exit = 1'b1;
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive(0, 0, 0, 0);
    step();
    drive(0, 0, 0, 0);
    step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] id;
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      id = $urandom;
      if (id == 26) id = 27;
      drive(id, $urandom, $urandom, 1'($urandom));
      if (i == 1) begin
        n_tests++;
        if ({bus.stall, bus.out_valid, bus.halt, bus.count, bus.out_data} !== '0) begin
          n_fail++;
          $display("FAIL reset_outputs: stall=%0b valid=%0b halt=%0b count=%0d data=%0h, all must be 0",
                   bus.stall, bus.out_valid, bus.halt, bus.count, bus.out_data);
        end
      end
      step();
    end
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 1);
      n_tests++;
      if (bus.out_valid !== 1'b0 || bus.count !== 4'd0 || bus.halt !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_idle: valid=%0b count=%0d halt=%0b, want 0 0 0", bus.out_valid, bus.count, bus.halt);
      end
      step();
    end
  endtask

  task automatic test_order();
    logic [31:0] vals [3] = '{32'd11, 32'd22, 32'd33};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      if (i < 3) drive(26, 1, vals[i], 1);
      else drive(0, 0, 0, 1);
      n_tests++;
      if (FWD ? (i < 3 && (bus.out_valid !== 1'b1 || bus.out_data !== vals[i] || bus.count !== 4'd0)) ||
                (i == 3 && bus.out_valid !== 1'b0)
              : (i == 0 && bus.out_valid !== 1'b0) ||
                (i > 0 && (bus.out_valid !== 1'b1 || bus.out_data !== vals[i-1] || bus.count !== 4'd1))) begin
        n_fail++;
        $display("FAIL order_cycle%0d: valid=%0b data=%0d count=%0d", i, bus.out_valid, bus.out_data, bus.count);
      end
      n_tests++;
      if (bus.stall !== 1'b0) begin
        n_fail++;
        $display("FAIL order_stall%0d: got %0b want 0", i, bus.stall);
      end
      step();
    end
    drive(0, 0, 0, 1);
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.count !== 4'd0) begin
      n_fail++;
      $display("FAIL order_end: valid=%0b count=%0d want 0 0", bus.out_valid, bus.count);
    end
    step();
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 1; i <= DEPTH; i++) begin
      drive(26, 1, i, 0);
      n_tests++;
      if (bus.stall !== 1'b0) begin
        n_fail++;
        $display("FAIL full_push%0d_stall: got %0b want 0", i, bus.stall);
      end
      step();
    end
    drive(26, 1, 9, 0);
    n_tests++;
    if (bus.count !== 4'd8 || bus.stall !== 1'b1 || bus.out_data !== 32'd1) begin
      n_fail++;
      $display("FAIL full_9th: count=%0d stall=%0b data=%0d want 8 1 1", bus.count, bus.stall, bus.out_data);
    end
    step();
    drive(26, 1, 9, 1);
    n_tests++;
    if (bus.stall !== 1'b1) begin
      n_fail++;
      $display("FAIL full_pop_same_cycle_stall: got %0b want 1", bus.stall);
    end
    step();
    drive(26, 1, 9, 0);
    n_tests++;
    if (bus.count !== 4'd7 || bus.stall !== 1'b0 || bus.out_data !== 32'd2) begin
      n_fail++;
      $display("FAIL full_after_pop: count=%0d stall=%0b data=%0d want 7 0 2", bus.count, bus.stall, bus.out_data);
    end
    step();
    for (int k = 2; k <= 9; k++) begin
      drive(0, 0, 0, 1);
      n_tests++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 32'(k)) begin
        n_fail++;
        $display("FAIL full_drain%0d: valid=%0b data=%0d want 1 %0d", k, bus.out_valid, bus.out_data, k);
      end
      step();
    end
    drive(0, 0, 0, 1);
    n_tests++;
    if (bus.count !== 4'd0 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL full_empty: count=%0d valid=%0b want 0 0", bus.count, bus.out_valid);
    end
    step();
  endtask

  task automatic test_exit_backlog();
    do_reset();
    for (int v = 5; v <= 7; v++) begin
      drive(26, 1, v, 0);
      step();
    end
    drive(26, 0, 0, 0);
    n_tests++;
    if (bus.stall !== 1'b0) begin
      n_fail++;
      $display("FAIL exit_accept_stall: got %0b want 0", bus.stall);
    end
    step();
    drive(26, 1, 8, 0);
    n_tests++;
    if (bus.stall !== 1'b1 || bus.halt !== 1'b0 || bus.count !== 4'd3) begin
      n_fail++;
      $display("FAIL exit_drain_disp: stall=%0b halt=%0b count=%0d want 1 0 3", bus.stall, bus.halt, bus.count);
    end
    step();
    drive(26, 5, 0, 0);
    n_tests++;
    if (bus.stall !== 1'b1) begin
      n_fail++;
      $display("FAIL exit_drain_exit_stall: got %0b want 1", bus.stall);
    end
    step();
    for (int v = 5; v <= 7; v++) begin
      drive(0, 0, 0, 1);
      n_tests++;
      if (bus.out_data !== 32'(v) || bus.halt !== 1'b0) begin
        n_fail++;
        $display("FAIL exit_emit%0d: data=%0d halt=%0b want %0d 0", v, bus.out_data, bus.halt, v);
      end
      step();
    end
    drive(0, 0, 0, 1);
    n_tests++;
    if (bus.halt !== 1'b0 || bus.count !== 4'd0) begin
      n_fail++;
      $display("FAIL exit_halt_early: halt=%0b count=%0d want 0 0", bus.halt, bus.count);
    end
    step();
    drive(0, 0, 0, 1);
    n_tests++;
    if (bus.halt !== 1'b1) begin
      n_fail++;
      $display("FAIL exit_halt_rise: got %0b want 1", bus.halt);
    end
    step();
  endtask

  task automatic test_exit_empty();
    do_reset();
    drive(26, 2, 0, 1);
    n_tests++;
    if (bus.stall !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_exit_stall: got %0b want 0", bus.stall);
    end
    step();
    drive(0, 0, 0, 1);
    n_tests++;
    if (bus.halt !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_halt_k: got %0b want 0", bus.halt);
    end
    step();
    for (int i = 0; i < 4; i++) begin
      drive(26, 1, 99, 1);
      n_tests++;
      if (bus.halt !== 1'b1 || bus.stall !== 1'b1 || bus.out_valid !== 1'b0 || bus.count !== 4'd0) begin
        n_fail++;
        $display("FAIL empty_halted%0d: halt=%0b stall=%0b valid=%0b count=%0d want 1 1 0 0",
                 i, bus.halt, bus.stall, bus.out_valid, bus.count);
      end
      step();
    end
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    for (int v = 1; v <= 3; v++) begin
      drive(26, 1, v, 0);
      step();
    end
    drive(26, 3, 0, 0);
    step();
    reset = 1'b0;
    drive(0, 0, 0, 0);
    step();
    reset = 1'b1;
    drive(26, 1, 42, 0);
    n_tests++;
    if (bus.count !== 4'd0 || bus.halt !== 1'b0 || bus.stall !== 1'b0 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL middrain_reset: count=%0d halt=%0b stall=%0b valid=%0b want 0 0 0 0",
               bus.count, bus.halt, bus.stall, bus.out_valid);
    end
    step();
    drive(0, 0, 0, 1);
    n_tests++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'd42 || bus.count !== 4'd1) begin
      n_fail++;
      $display("FAIL middrain_emit: valid=%0b data=%0d count=%0d want 1 42 1", bus.out_valid, bus.out_data, bus.count);
    end
    step();
    drive(0, 0, 0, 1);
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.count !== 4'd0) begin
      n_fail++;
      $display("FAIL middrain_empty: valid=%0b count=%0d want 0 0", bus.out_valid, bus.count);
    end
    step();
  endtask

  task automatic test_random();
    int n;
    bit disp, ex, run, fw, e_stall, e_valid;
    logic [31:0] e_data, id, r;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      reset = ($urandom_range(0, 79) == 0) ? 1'b0 : 1'b1;
      id = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 40) : 32'd26;
      r = ($urandom_range(0, 29) == 0) ? $urandom_range(2, 9) : 32'd1;
      drive(id, r, $urandom, 1'($urandom_range(0, 2) != 0 ? 1 : 0) & 1'($urandom));
      n = mq.size();
      disp = id == 26 && r == 1;
      ex = id == 26 && r != 1;
      run = !m_exit && !m_halt;
      fw = FWD && run && n == 0 && disp && bus.out_ready;
      e_stall = (disp && (!run || n == DEPTH)) || (ex && !run);
      e_valid = n != 0 || fw;
      e_data = fw ? bus.rt : (n != 0 ? mq[0] : 32'd0);
      n_tests++;
      if (bus.stall !== e_stall || bus.out_valid !== e_valid || bus.out_data !== e_data ||
          bus.halt !== m_halt || bus.count !== 4'(n)) begin
        n_fail++;
        $display("FAIL rand_cycle%0d: got stall=%0b valid=%0b data=%0h halt=%0b count=%0d want %0b %0b %0h %0b %0d",
                 c, bus.stall, bus.out_valid, bus.out_data, bus.halt, bus.count, e_stall, e_valid, e_data, m_halt, n);
      end
      step();
    end
    reset = 1'b1;
  endtask

  initial begin
    bus.instr_ID = '0;
    bus.rs = '0;
    bus.rt = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_order();
    test_full();
    test_exit_backlog();
    test_exit_empty();
    test_reset_mid_drain();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
